// File: rtl/button_conditioner.sv
// Per-button input conditioning: 2-flop synchroniser, debounce, and registered
// press / release / auto-repeat pulses for N_BTN independent channels.
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned RPT_W           = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] repeat_o
);

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] db_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic             flip;
    logic             level_next;

    // flip: the synchronised input has differed for DEBOUNCE_CYCLES edges
    assign flip       = (sync2[i] != level_q) && (db_cnt == DB_LAST);
    assign level_next = flip ? sync2[i] : level_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= flip &  sync2[i];
        release_q <= flip & ~sync2[i];
        if (sync2[i] == level_q || flip) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
        if (flip) begin
          level_q <= sync2[i];
        end
      end
    end

    if (REPEAT_DELAY > 0) begin : g_rpt
      localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

      logic [RPT_W-1:0] rpt_cnt;
      phase_t           phase;
      logic             hit;

      assign hit = (phase == PH_DELAY) ? (rpt_cnt == DLY_LAST)
                                       : (rpt_cnt == PER_LAST);

      // Compared one below the target so the pulse register lands on the
      // edge the counter would reach REPEAT_DELAY / REPEAT_PERIOD.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rpt_cnt  <= '0;
          phase    <= PH_DELAY;
          repeat_q <= 1'b0;
        end else if (!level_q || !level_next) begin
          rpt_cnt  <= '0;
          phase    <= PH_DELAY;
          repeat_q <= 1'b0;
        end else if (hit) begin
          rpt_cnt  <= '0;
          phase    <= PH_PERIOD;
          repeat_q <= 1'b1;
        end else begin
          rpt_cnt  <= rpt_cnt + 1'b1;
          repeat_q <= 1'b0;
        end
      end
    end else begin : g_norpt
      assign repeat_q = 1'b0;
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign repeat_o[i]  = repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length / elapsed-time model
// pushes expected outputs each edge; a negedge monitor pops and compares.
module tb_button_conditioner;

  localparam int N   = 5;
  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] level_o, press_o, release_o, repeat_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [4*N-1:0] exp_q[$];

  button_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(2),
    .REPEAT_DELAY(DLY),
    .REPEAT_PERIOD(PER),
    .RPT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn),
    .level_o(level_o),
    .press_o(press_o),
    .release_o(release_o),
    .repeat_o(repeat_o)
  );

  always #5 clk = ~clk;

  // Reference model: s is btn delayed two edges; level flips after D
  // consecutive sampled mismatches; repeats at DLY, DLY+PER, ... after press.
  bit s1[N], s2[N], lv[N];
  int run[N], held[N];

  always @(posedge clk) begin : model
    logic [N-1:0] el, ep, er, erp;
    bit s;
    el = '0; ep = '0; er = '0; erp = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        s1[i] = 0; s2[i] = 0; lv[i] = 0; run[i] = 0; held[i] = 0;
      end else begin
        s = s2[i];
        s2[i] = s1[i];
        s1[i] = btn[i];
        if (s != lv[i]) begin
          run[i]++;
          if (run[i] == D) begin
            lv[i]  = s;
            run[i] = 0;
            if (s) ep[i] = 1'b1;
            else   er[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
        if (lv[i]) begin
          if (ep[i]) held[i] = 0;
          else       held[i]++;
          if (held[i] >= DLY && (held[i] - DLY) % PER == 0) erp[i] = 1'b1;
        end else begin
          held[i] = 0;
        end
      end
      el[i] = lv[i];
    end
    exp_q.push_back({el, ep, er, erp});
  end

  always @(negedge clk) begin : monitor
    logic [4*N-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {level_o, press_o, release_o, repeat_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got lvl/prs/rel/rpt=%h required=%h", $time, a, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, got, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Steps until every bit of m pulses on press_o (rel=0) or release_o (rel=1).
  task automatic wait_mask(input logic [N-1:0] m, input bit rel, input int maxc, output int k);
    k = 0;
    for (int c = 1; c <= maxc; c++) begin
      step(1);
      if (((rel ? release_o : press_o) & m) == m) begin
        k = c;
        break;
      end
    end
  endtask

  initial begin
    int k, cnt;
    logic seen, rel1, rel3;

    // reset with all buttons held
    btn = '1;
    rst = 1'b1;
    step(3);
    check("rst_outputs_zero", {level_o, press_o, release_o, repeat_o}, 0);
    rst = 1'b0;
    wait_mask('1, 1'b0, 12, k);
    check("reset_press_latency", k, 6);
    check("reset_level_all", level_o, 5'h1F);
    btn = '0;
    step(12);

    // clean press / release on channel 0
    btn[0] = 1'b1;
    wait_mask(5'b00001, 1'b0, 12, k);
    check("press0_latency", k, 6);
    step(24);
    btn[0] = 1'b0;
    wait_mask(5'b00001, 1'b1, 40, k);
    check("release0_seen", k != 0, 1);
    step(4);

    // bounce rejection on channel 2
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      btn[2] = ~btn[2];
      repeat (2) begin
        step(1);
        seen |= level_o[2] | press_o[2] | release_o[2];
      end
    end
    step(6);
    seen |= level_o[2] | press_o[2] | release_o[2];
    check("bounce2_quiet", seen, 0);

    // auto-repeat on channel 4
    btn[4] = 1'b1;
    wait_mask(5'b10000, 1'b0, 12, k);
    check("press4_latency", k, 6);
    cnt = 0;
    repeat (25) begin
      step(1);
      if (repeat_o[4]) cnt++;
    end
    check("repeat4_count", cnt, 6);
    btn[4] = 1'b0;
    wait_mask(5'b10000, 1'b1, 12, k);
    check("release4_seen", k != 0, 1);
    cnt = 0;
    repeat (20) begin
      step(1);
      if (repeat_o[4]) cnt++;
    end
    check("repeat4_after_release", cnt, 0);

    // simultaneous channels 1 and 3
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    wait_mask(5'b01010, 1'b0, 12, k);
    check("press13_same_cycle", k, 6);
    step(2);
    btn[3] = 1'b0;
    rel1 = 1'b0;
    rel3 = 1'b0;
    repeat (15) begin
      step(1);
      rel1 |= release_o[1];
      rel3 |= release_o[3];
    end
    check("release3_only", {rel1, rel3}, 2'b01);
    check("level1_held", level_o[1], 1);
    btn[1] = 1'b0;
    step(12);

    // reset in the middle of debouncing channel 0
    btn[0] = 1'b1;
    step(4);
    check("no_early_press0", press_o[0] | level_o[0], 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_mask(5'b00001, 1'b0, 12, k);
    check("press0_after_reset", k, 6);
    btn = '0;
    step(12);

    // randomized mix of clean holds, bounces and occasional resets
    for (int blk = 0; blk < 20; blk++) begin
      int unsigned span;
      span = ($urandom_range(0, 1) == 0) ? 2 : 40;
      repeat (100) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, span) == 0) btn[i] = ~btn[i];
        if ($urandom_range(0, 400) == 0) begin
          rst = 1'b1;
          #1;
          check("async_reset_drop", {level_o, press_o, release_o, repeat_o}, 0);
        end else begin
          rst = 1'b0;
        end
        step(1);
      end
    end
    rst = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage between the raw io_button pins and the user logic: the digit counter and the display-select shifter.
- Synchronises each of N asynchronous push-button inputs to clk and debounces it.
- Produces a clean level plus single-cycle press, release and auto-repeat pulses per button.
- Downstream logic samples these pulses synchronously instead of clocking on raw button edges.

Parameters:
N_BTN, 5, number of button channels
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the accepted level before the level changes (10 ms at 100 MHz); must be >= 2
CNT_W, 20, width of the per-button debounce counter; must hold DEBOUNCE_CYCLES-1
REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse; 0 disables auto-repeat
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; must be >= 1
RPT_W, 26, width of the per-button repeat counter; must hold max(REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous active-high reset
btn_in  input  N_BTN  raw button pins, asynchronous, active-high
level_o  output  N_BTN  debounced button level
press_o  output  N_BTN  one-cycle pulse on debounced 0->1
release_o  output  N_BTN  one-cycle pulse on debounced 1->0
repeat_o  output  N_BTN  one-cycle auto-repeat pulse while held

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is cleared on rst assertion, independent of clk. All outputs are registered.
- Reset values:
  - level_o, press_o, release_o, repeat_o = 0.
  - Synchroniser flops, debounce counters and repeat counters = 0.
- Channels are fully independent and identical. Simultaneous activity on any subset of buttons produces independent outputs with no priority.
- Synchroniser: 2 flops per bit; s[i] is the second-stage output. No logic sits between the stages.
- Debounce, per channel:
  - If s[i] equals level_o[i], the counter is set to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s[i] still differs, the next edge sets level_o[i] = s[i] and the counter to 0.
  - Any single cycle with s[i] equal to level_o[i] restarts the count from 0, which rejects bounces.
- Latency: a clean step on btn_in[i] that is held is first captured at edge E. level_o[i] changes at edge E + 1 + DEBOUNCE_CYCLES.
- Pulses:
  - press_o[i] is high for exactly the first cycle in which level_o[i] = 1.
  - release_o[i] is high for exactly the first cycle in which level_o[i] = 0 after having been 1.
  - Neither can be high in consecutive cycles, and the two are never high together.
- Auto-repeat, per channel, only when REPEAT_DELAY > 0:
  - The repeat counter is cleared in the press cycle and counts every cycle while level_o[i] = 1.
  - Phase 1: when the counter reaches REPEAT_DELAY, repeat_o[i] pulses for one cycle and the counter reloads to 0.
  - Phase 2: thereafter it pulses each time the counter reaches REPEAT_PERIOD.
  - First repeat occurs REPEAT_DELAY cycles after press_o; subsequent repeats are every REPEAT_PERIOD cycles.
  - When level_o[i] = 0, the counter and phase are held at 0 and repeat_o[i] = 0. No repeat fires in the release cycle or after it.
  - repeat_o[i] and press_o[i] are never high together.
- REPEAT_DELAY = 0: repeat_o is tied to 0 and the repeat counters are optimised away.
- Reset mid-operation: all outputs drop within the reset assertion. A button held through reset release is re-qualified from scratch, so it produces a fresh press_o after the full latency.
- Counters never wrap. Debounce counter maximum is DEBOUNCE_CYCLES-1; repeat counter maximum is max(REPEAT_DELAY, REPEAT_PERIOD).

Test Plan:
(all with N_BTN=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- Reset: drive btn_in=5'h1F and assert rst for 3 cycles, then release -> all outputs 0 during rst; level_o=5'h1F and press_o=5'h1F for one cycle, 5 edges after the first post-reset capture edge.
- Clean press/release: btn_in[0] 0->1, held for 30 cycles, then 1->0 -> level_o[0] rises 5 edges after capture; press_o[0] is one cycle wide; release_o[0] is one cycle, 5 edges after the falling capture.
- Bounce rejection: btn_in[2] toggles every 2 cycles for 20 cycles and ends at 0 -> level_o[2], press_o[2] and release_o[2] stay 0 throughout.
- Auto-repeat: hold btn_in[4] for 25 cycles past press_o -> repeat_o[4] pulses at press+10, +13, +16, +19, +22, +25; no repeat pulse after release_o[4].
- Simultaneous channels: btn_in[1] and btn_in[3] rise on the same edge, btn_in[3] released 8 cycles later -> both press on the same cycle; release_o[3] only; channel 1 unaffected.
- Reset mid-debounce: btn_in[0] rises; rst pulses when the counter is 2; btn_in[0] held -> no press until the full 5 edges after post-reset capture.
